// File: rtl/ccff_loader.sv
// rtl/ccff_loader.sv - Loads host words serially into a configuration flip-flop chain and reads back the chain tail.
module ccff_loader #(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 14
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              ccff_shift_en,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
    localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q;
    logic [WORD_W-1:0] shreg_q;
    logic [WORD_W-1:0] rb_shreg_q;
    logic [WORD_W-1:0] rb_data_q;
    logic              rb_valid_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [IDX_W-1:0]  bit_idx_q;
    logic [IDX_W-1:0]  rb_cnt_q;

    logic [WORD_W-1:0] rb_next;
    logic              last_bit;
    logic              rb_word_end;

    assign rb_next     = (rb_shreg_q << 1) | WORD_W'(ccff_tail);
    assign last_bit    = (bit_cnt_q == LAST_BIT);
    assign rb_word_end = (rb_cnt_q == LAST_IDX) || last_bit;

    // Outputs decode straight from the state register so reset clears them without waiting for a clock.
    assign cfg_ready     = (state_q == LOAD);
    assign ccff_shift_en = (state_q == SHIFT);
    assign ccff_head     = (state_q == SHIFT) & shreg_q[WORD_W-1];
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign rb_data       = rb_data_q;
    assign rb_valid      = rb_valid_q;

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            rb_shreg_q <= '0;
            rb_data_q  <= '0;
            rb_valid_q <= 1'b0;
            bit_cnt_q  <= '0;
            bit_idx_q  <= '0;
            rb_cnt_q   <= '0;
        end else begin
            rb_valid_q <= 1'b0;
            if (abort && (state_q != IDLE)) begin
                state_q    <= IDLE;
                bit_cnt_q  <= '0;
                bit_idx_q  <= '0;
                rb_cnt_q   <= '0;
                rb_shreg_q <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            state_q   <= LOAD;
                            bit_cnt_q <= '0;
                            bit_idx_q <= '0;
                            rb_cnt_q  <= '0;
                        end
                    end
                    LOAD: begin
                        if (cfg_valid) begin
                            shreg_q <= cfg_data;
                            state_q <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        shreg_q    <= shreg_q << 1;
                        bit_cnt_q  <= bit_cnt_q + CNT_W'(1);
                        bit_idx_q  <= (bit_idx_q == LAST_IDX) ? '0 : bit_idx_q + IDX_W'(1);
                        rb_shreg_q <= rb_next;
                        // A short final word is left-aligned so readback matches the host word layout.
                        if (rb_word_end) begin
                            rb_data_q  <= rb_next << (LAST_IDX - rb_cnt_q);
                            rb_valid_q <= 1'b1;
                            rb_cnt_q   <= '0;
                        end else begin
                            rb_cnt_q <= rb_cnt_q + IDX_W'(1);
                        end
                        if (last_bit) begin
                            state_q <= DONE;
                        end else if (bit_idx_q == LAST_IDX) begin
                            state_q <= LOAD;
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ccff_loader.sv
// tb/tb_ccff_loader.sv - Self-checking bench for ccff_loader with a chain model and a word-level reference.
module tb_ccff_loader;

    localparam int W = 8;
    localparam int L = 14;

    logic         prog_clk     = 1'b0;
    logic         prog_reset_n = 1'b0;
    logic         start        = 1'b0;
    logic         abort        = 1'b0;
    logic [W-1:0] cfg_data     = '0;
    logic         cfg_valid    = 1'b0;
    logic         cfg_ready;
    logic         ccff_head;
    logic         ccff_tail;
    logic         ccff_shift_en;
    logic [W-1:0] rb_data;
    logic         rb_valid;
    logic         busy;
    logic         done;

    int errors = 0;
    int checks = 0;

    logic [L-1:0] chain;
    logic         preload = 1'b0;

    logic [L-1:0] got_stream;
    int           nshift, gaps, first_gap, ndone, nrb;
    logic         timeout, busy_after_abort;
    logic [W-1:0] rbw [4];

    ccff_loader #(.WORD_W(W), .CHAIN_LEN(L)) dut (
        .prog_clk      (prog_clk),
        .prog_reset_n  (prog_reset_n),
        .start         (start),
        .abort         (abort),
        .cfg_data      (cfg_data),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .ccff_head     (ccff_head),
        .ccff_tail     (ccff_tail),
        .ccff_shift_en (ccff_shift_en),
        .rb_data       (rb_data),
        .rb_valid      (rb_valid),
        .busy          (busy),
        .done          (done)
    );

    always #5 prog_clk = ~prog_clk;

    // External configuration chain: gated prog_clk shifts head in, tail is the oldest bit.
    always @(posedge prog_clk) begin
        if (preload) chain <= '1;
        else if (ccff_shift_en) chain <= {chain[L-2:0], ccff_head};
    end
    assign ccff_tail = chain[L-1];

    function automatic logic [L-1:0] exp_stream(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [L-1:0] s;
        logic [W-1:0] wd;
        s = '0;
        for (int i = 0; i < L; i++) begin
            wd = (i < W) ? a : b;
            s[L-1-i] = wd[W-1-(i%W)];
        end
        return s;
    endfunction

    function automatic logic [W-1:0] exp_rb(input logic [L-1:0] c, input int k);
        logic [W-1:0] r;
        int i;
        r = '0;
        for (int j = 0; j < W; j++) begin
            i = k*W + j;
            if (i < L) r[W-1-j] = c[L-1-i];
        end
        return r;
    endfunction

    task automatic do_preload();
        @(negedge prog_clk) preload = 1'b1;
        @(negedge prog_clk) preload = 1'b0;
    endtask

    task automatic do_load(input logic [W-1:0] w0, input logic [W-1:0] w1,
                           input int stall, input int abort_bit, input int start_bit);
        logic [W-1:0] words [2];
        int wp, stall_left, pend, settle;
        words[0] = w0; words[1] = w1;
        wp = 0; stall_left = stall; pend = 0; settle = -1;
        got_stream = '0; nshift = 0; gaps = 0; first_gap = -1; ndone = 0; nrb = 0;
        busy_after_abort = 1'bx;
        for (int k = 0; k < 4; k++) rbw[k] = '0;
        @(negedge prog_clk);
        start = 1'b1; cfg_data = w0; cfg_valid = 1'b1;
        for (int c = 0; c < 100 && settle != 0; c++) begin
            @(negedge prog_clk);
            start = 1'b0;
            if (abort) begin
                abort = 1'b0;
                busy_after_abort = 1'bx;
            end else if (settle == 4 && abort_bit >= 0) begin
                busy_after_abort = 1'bx;
            end
            if (settle > 0) settle--;
            if (abort_bit >= 0 && settle == 3 && ndone == 0) busy_after_abort = busy;
            if (ccff_shift_en) begin
                if (pend > 0) begin
                    if (first_gap < 0) first_gap = nshift;
                    gaps += pend;
                    pend = 0;
                end
                if (nshift < L) got_stream[L-1-nshift] = ccff_head;
                if (nshift == abort_bit) begin abort = 1'b1; settle = 4; end
                if (nshift == start_bit) start = 1'b1;
                nshift++;
            end else if (nshift > 0) begin
                pend++;
            end
            if (rb_valid) begin
                if (nrb < 4) rbw[nrb] = rb_data;
                nrb++;
            end
            if (done) begin
                ndone++;
                if (settle < 0) settle = 4;
            end
            if (wp < 2) begin
                if (cfg_ready && wp == 1 && stall_left > 0) begin
                    cfg_valid = 1'b0;
                    stall_left--;
                end else begin
                    cfg_valid = !(wp == 1 && stall_left > 0);
                    cfg_data  = words[wp];
                end
                if (cfg_ready && cfg_valid) wp++;
            end else begin
                cfg_valid = 1'b0;
            end
        end
        timeout = (settle != 0);
        start = 1'b0; abort = 1'b0; cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        prog_reset_n = 1'b0;
        repeat (3) @(negedge prog_clk);
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL reset_cfg_ready: got %b expected 0", cfg_ready); end
        checks++; if (ccff_head !== 1'b0) begin errors++; $display("FAIL reset_head: got %b expected 0", ccff_head); end
        checks++; if (ccff_shift_en !== 1'b0) begin errors++; $display("FAIL reset_shift_en: got %b expected 0", ccff_shift_en); end
        checks++; if (rb_valid !== 1'b0) begin errors++; $display("FAIL reset_rb_valid: got %b expected 0", rb_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (rb_data !== '0) begin errors++; $display("FAIL reset_rb_data: got %h expected 00", rb_data); end
        prog_reset_n = 1'b1;
        repeat (3) @(negedge prog_clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_idle: busy got %b expected 0", busy); end
    endtask

    task automatic test_full_load();
        do_preload();
        do_load(8'hA5, 8'h3C, 0, -1, -1);
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL full_timeout: got %b expected 0", timeout); end
        checks++; if (got_stream !== 14'b10100101001111) begin errors++; $display("FAIL full_stream: got %b expected 10100101001111", got_stream); end
        checks++; if (nshift != 14) begin errors++; $display("FAIL full_shift_cycles: got %0d expected 14", nshift); end
        checks++; if (gaps != 1) begin errors++; $display("FAIL full_gap_cycles: got %0d expected 1", gaps); end
        checks++; if (first_gap != 8) begin errors++; $display("FAIL full_gap_pos: got %0d expected 8", first_gap); end
        checks++; if (ndone != 1) begin errors++; $display("FAIL full_done_count: got %0d expected 1", ndone); end
        checks++; if (nrb != 2) begin errors++; $display("FAIL full_rb_count: got %0d expected 2", nrb); end
        checks++; if (rbw[0] !== 8'hFF) begin errors++; $display("FAIL full_rb0: got %h expected ff", rbw[0]); end
        checks++; if (rbw[1] !== 8'hFC) begin errors++; $display("FAIL full_rb1: got %h expected fc", rbw[1]); end
    endtask

    task automatic test_readback();
        do_load(8'hA5, 8'h3C, 0, -1, -1);
        checks++; if (nrb != 2) begin errors++; $display("FAIL rb_count: got %0d expected 2", nrb); end
        checks++; if (rbw[0] !== 8'hA5) begin errors++; $display("FAIL rb_word0: got %h expected a5", rbw[0]); end
        checks++; if (rbw[1] !== 8'h3C) begin errors++; $display("FAIL rb_word1: got %h expected 3c", rbw[1]); end
    endtask

    task automatic test_stall();
        do_load(8'hA5, 8'h3C, 5, -1, -1);
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL stall_timeout: got %b expected 0", timeout); end
        checks++; if (got_stream !== 14'b10100101001111) begin errors++; $display("FAIL stall_stream: got %b expected 10100101001111", got_stream); end
        checks++; if (gaps != 6) begin errors++; $display("FAIL stall_gap_cycles: got %0d expected 6", gaps); end
        checks++; if (first_gap != 8) begin errors++; $display("FAIL stall_gap_pos: got %0d expected 8", first_gap); end
        checks++; if (ndone != 1) begin errors++; $display("FAIL stall_done_count: got %0d expected 1", ndone); end
    endtask

    task automatic test_abort();
        do_load(8'hA5, 8'h3C, 0, 5, -1);
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL abort_timeout: got %b expected 0", timeout); end
        checks++; if (busy_after_abort !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy_after_abort); end
        checks++; if (ndone != 0) begin errors++; $display("FAIL abort_done: got %0d expected 0", ndone); end
        checks++; if (nrb != 0) begin errors++; $display("FAIL abort_rb_valid: got %0d expected 0", nrb); end
        do_preload();
        do_load(8'hA5, 8'h3C, 0, -1, -1);
        checks++; if (got_stream !== 14'b10100101001111) begin errors++; $display("FAIL abort_reload_stream: got %b expected 10100101001111", got_stream); end
        checks++; if (gaps != 1 || first_gap != 8) begin errors++; $display("FAIL abort_reload_gap: got %0d@%0d expected 1@8", gaps, first_gap); end
        checks++; if (ndone != 1) begin errors++; $display("FAIL abort_reload_done: got %0d expected 1", ndone); end
        checks++; if (rbw[0] !== 8'hFF || rbw[1] !== 8'hFC) begin errors++; $display("FAIL abort_reload_rb: got %h %h expected ff fc", rbw[0], rbw[1]); end
    endtask

    task automatic test_start_while_busy();
        do_load(8'hA5, 8'h3C, 0, -1, 3);
        checks++; if (got_stream !== 14'b10100101001111) begin errors++; $display("FAIL swb_stream: got %b expected 10100101001111", got_stream); end
        checks++; if (ndone != 1 || nshift != 14) begin errors++; $display("FAIL swb_done_shift: got %0d/%0d expected 1/14", ndone, nshift); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL swb_idle_after: busy got %b expected 0", busy); end
    endtask

    task automatic test_random();
        logic [L-1:0] exp_chain;
        logic [W-1:0] a, b;
        int stall;
        do_preload();
        exp_chain = '1;
        for (int n = 0; n < 6; n++) begin
            a = W'($urandom);
            b = W'($urandom);
            stall = $urandom_range(0, 3);
            do_load(a, b, stall, -1, -1);
            checks++; if (got_stream !== exp_stream(a, b)) begin errors++; $display("FAIL rand_stream[%0d]: got %b expected %b", n, got_stream, exp_stream(a, b)); end
            checks++; if (rbw[0] !== exp_rb(exp_chain, 0) || rbw[1] !== exp_rb(exp_chain, 1) || nrb != 2) begin
                errors++; $display("FAIL rand_rb[%0d]: got %h %h (%0d) expected %h %h (2)", n, rbw[0], rbw[1], nrb, exp_rb(exp_chain, 0), exp_rb(exp_chain, 1));
            end
            checks++; if (ndone != 1 || gaps != stall + 1) begin errors++; $display("FAIL rand_done_gap[%0d]: got %0d/%0d expected 1/%0d", n, ndone, gaps, stall + 1); end
            exp_chain = exp_stream(a, b);
        end
    endtask

    task automatic test_reset_mid_shift();
        bit seen_shift, seen_done, seen_busy;
        seen_shift = 0; seen_done = 0; seen_busy = 0;
        @(negedge prog_clk);
        start = 1'b1; cfg_data = 8'hA5; cfg_valid = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
        for (int c = 0; c < 20 && !seen_shift; c++) begin
            @(negedge prog_clk);
            if (ccff_shift_en) seen_shift = 1;
        end
        checks++; if (!seen_shift) begin errors++; $display("FAIL rst_mid_reach_shift: got 0 expected 1"); end
        repeat (2) @(negedge prog_clk);
        #2 prog_reset_n = 1'b0;
        #1;
        checks++; if ({cfg_ready, ccff_head, ccff_shift_en, rb_valid, busy, done} !== 6'b0) begin
            errors++; $display("FAIL rst_mid_outputs: got %b expected 000000", {cfg_ready, ccff_head, ccff_shift_en, rb_valid, busy, done});
        end
        checks++; if (rb_data !== '0) begin errors++; $display("FAIL rst_mid_rb_data: got %h expected 00", rb_data); end
        @(negedge prog_clk);
        prog_reset_n = 1'b1;
        cfg_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge prog_clk);
            if (done) seen_done = 1;
            if (busy) seen_busy = 1;
        end
        checks++; if (seen_done || seen_busy) begin errors++; $display("FAIL rst_mid_after: done/busy got %b/%b expected 0/0", seen_done, seen_busy); end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_readback();
        test_stall();
        test_abort();
        test_start_while_busy();
        test_random();
        test_reset_mid_shift();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ccff_loader.md
CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 Parameter WORD_W, default 8, SHALL set the width of host configuration words and readback words.
REQ-002 Parameter CHAIN_LEN, default 14, SHALL set the number of bits shifted per load (one connection block: 7 muxes x 2 SRAM bits).
REQ-003 Port prog_clk, input, 1: the only clock; all state SHALL update on its rising edge.
REQ-004 Port prog_reset_n, input, 1: asynchronous, active-low reset.
REQ-005 Port start, input, 1: single-cycle request to begin a load.
REQ-006 Port abort, input, 1: terminates an in-progress load.
REQ-007 Port cfg_data, input, WORD_W: host configuration word; MSB is shifted first.
REQ-008 Port cfg_valid, input, 1: cfg_data is valid.
REQ-009 Port cfg_ready, output, 1: loader accepts cfg_data this cycle.
REQ-010 Port ccff_head, output, 1: serial data driven to the head of the configuration chain.
REQ-011 Port ccff_tail, input, 1: serial data returned from the tail of the configuration chain.
REQ-012 Port ccff_shift_en, output, 1: clock-enable for the chain's prog_clk gate; the chain advances one bit on each cycle it is high.
REQ-013 Port rb_data, output, WORD_W: readback word captured from ccff_tail.
REQ-014 Port rb_valid, output, 1: one-cycle pulse qualifying rb_data; there is no backpressure.
REQ-015 Port busy, output, 1: high in every state except IDLE.
REQ-016 Port done, output, 1: one-cycle pulse on completion of a load.

Function
REQ-017 The FSM SHALL have four states: IDLE, LOAD, SHIFT and DONE.
REQ-018 In IDLE, start=1 SHALL move the FSM to LOAD and clear bit_cnt (total bits shifted) and bit_idx (bit index within the current word).
REQ-019 In LOAD, cfg_ready SHALL be 1; when cfg_valid&cfg_ready, cfg_data SHALL be captured into shreg and the FSM SHALL move to SHIFT. cfg_ready SHALL be 0 in all other states.
REQ-020 In SHIFT, every cycle SHALL:
- drive ccff_shift_en=1 and ccff_head=shreg[WORD_W-1];
- shift shreg left by one;
- increment bit_cnt and bit_idx.
REQ-021 In SHIFT, ccff_shift_en SHALL be 1 only in SHIFT cycles; in all other states ccff_shift_en=0 and ccff_head=0.
REQ-022 SHIFT exit conditions:
- bit_cnt==CHAIN_LEN-1 SHALL go to DONE (takes priority);
- otherwise bit_idx==WORD_W-1 SHALL go to LOAD, leaving a one-cycle gap between words;
- otherwise the FSM SHALL stay in SHIFT.
REQ-023 The final word MAY be partial; its unused low bits SHALL be discarded, and no additional word SHALL be requested.
REQ-024 When cfg_valid=0 in LOAD, the FSM SHALL wait indefinitely with ccff_shift_en=0, so the chain holds its contents.
REQ-025 In DONE, done=1 for exactly one cycle, then the FSM SHALL go to IDLE.
REQ-026 Readback capture: on each SHIFT cycle, ccff_tail SHALL be shifted into rb_shreg at the LSB end.
REQ-027 Readback output:
- after WORD_W captures, or after the capture in the final SHIFT cycle, rb_data SHALL present the captured bits left-aligned, with unused LSBs zero;
- rb_valid=1 on the following cycle;
- the capture count SHALL then clear.
REQ-028 start SHALL be ignored when busy=1.
REQ-029 abort SHALL have priority over all transitions:
- in any non-IDLE state, the FSM SHALL go to IDLE next cycle;
- done SHALL not pulse and rb_valid SHALL not pulse for the partial word;
- the counters SHALL clear.
REQ-030 bit_cnt SHALL be wide enough to hold CHAIN_LEN-1 (clog2(CHAIN_LEN), minimum 1); bit_idx SHALL be clog2(WORD_W) bits and wrap to 0 after WORD_W-1.

Reset
REQ-031 prog_reset_n=0 SHALL asynchronously force:
- the FSM to IDLE;
- shreg, rb_shreg, rb_data, bit_cnt, bit_idx and the capture count to 0;
- cfg_ready, ccff_head, ccff_shift_en, rb_valid, busy and done to 0.
REQ-032 Reset asserted mid-load SHALL abandon the load with no done pulse; after release, the FSM SHALL remain in IDLE until a new start.

Verification
REQ-033 Full load: defaults, words 0xA5 then 0x3C, cfg_valid always high -> ccff_head serial bits are 1,0,1,0,0,1,0,1,0,0,1,1,1,1; ccff_shift_en high for exactly 14 cycles with one gap cycle after bit 8; done pulses once.
REQ-034 Readback: ccff_tail driven by a 14-stage chain model preloaded with 0x3FFF, then run the REQ-033 load -> rb_data=0xFF then rb_data=0xFC, each with a one-cycle rb_valid; a second identical load returns 0xA5 then 0x3C.
REQ-035 Stall: cfg_valid held low for 5 cycles before the second word -> ccff_shift_en=0 for those cycles; serial stream and done identical to REQ-033.
REQ-036 Abort: abort asserted at bit 5 -> busy=0 next cycle, no done and no rb_valid; a following start with 0xA5/0x3C reproduces REQ-033 exactly.
REQ-037 Reset and start-while-busy: start pulsed during SHIFT -> ignored; prog_reset_n pulsed low mid-SHIFT -> all outputs 0 immediately with no done pulse.
